// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves one decoded B-type branch at a time using a shared ALU.
//   IDLE : waits for br_valid, latches the branch operands.
//   CMP  : drives the compare through the shared ALU and registers taken/illegal.
//   TGT  : reuses the ALU adder for pc + (taken ? imm : 4), registers target/misalign.
//   RESP : presents the redirect until the consumer accepts it.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   br_valid/br_ready, br_*     branch request handshake and payload
//   alu_op/alu_cmp_op/alu_a/b   shared ALU drive
//   alu_result, alu_cmp_flag    combinational ALU response
//   flush                       synchronous kill of any in-flight branch
//   redir_valid/redir_ready     redirect handshake; redir_* payload is zero while invalid
//   taken_cnt                   count of accepted taken redirects (wraps)
module branch_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic [XLEN-1:0] br_rs1_val,
    input  logic [XLEN-1:0] br_rs2_val,
    input  logic [3:0]      br_alu_op,
    input  logic [2:0]      br_cmp_op,
    output logic [3:0]      alu_op,
    output logic [2:0]      alu_cmp_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_cmp_flag,
    input  logic            flush,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic            redir_taken,
    output logic            redir_illegal,
    output logic            redir_misalign,
    output logic [XLEN-1:0] redir_target,
    output logic [31:0]     taken_cnt
);
    localparam logic [3:0] ALU_ADD     = 4'h0;
    localparam logic [3:0] ALU_NOP     = 4'hF;
    localparam logic [2:0] ALU_CMP_NOP = 3'h0;

    typedef enum logic [1:0] {IDLE, CMP, TGT, RESP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [3:0]      alu_op;
        logic [2:0]      cmp_op;
    } br_req_t;

    state_t          state;
    br_req_t         req;
    logic            taken_q;
    logic            illegal_q;
    logic            misalign_q;
    logic            vld_q;
    logic [XLEN-1:0] target_q;
    logic            cmp_illegal;

    assign cmp_illegal = (req.cmp_op == ALU_CMP_NOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req        <= '0;
            taken_q    <= 1'b0;
            illegal_q  <= 1'b0;
            misalign_q <= 1'b0;
            vld_q      <= 1'b0;
            target_q   <= '0;
            taken_cnt  <= '0;
        end else if (flush) begin
            // Kill wins over both handshakes; the counter is left untouched.
            state      <= IDLE;
            taken_q    <= 1'b0;
            illegal_q  <= 1'b0;
            misalign_q <= 1'b0;
            vld_q      <= 1'b0;
            target_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (br_valid) begin
                        req.pc     <= br_pc;
                        req.imm    <= br_imm;
                        req.rs1    <= br_rs1_val;
                        req.rs2    <= br_rs2_val;
                        req.alu_op <= br_alu_op;
                        req.cmp_op <= br_cmp_op;
                        taken_q    <= 1'b0;
                        illegal_q  <= 1'b0;
                        misalign_q <= 1'b0;
                        target_q   <= '0;
                        state      <= CMP;
                    end
                end
                CMP: begin
                    // An unused compare slot is illegal and never redirects.
                    illegal_q <= cmp_illegal;
                    taken_q   <= alu_cmp_flag & ~cmp_illegal;
                    state     <= TGT;
                end
                TGT: begin
                    target_q   <= alu_result;
                    misalign_q <= taken_q & (alu_result[1:0] != 2'b00);
                    vld_q      <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (redir_ready) begin
                        vld_q <= 1'b0;
                        state <= IDLE;
                        if (taken_q) taken_cnt <= taken_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shared ALU drive is a pure decode of the registered state.
    always_comb begin
        alu_op     = ALU_NOP;
        alu_cmp_op = ALU_CMP_NOP;
        alu_a      = '0;
        alu_b      = '0;
        case (state)
            CMP: begin
                alu_op     = req.alu_op;
                alu_cmp_op = req.cmp_op;
                alu_a      = req.rs1;
                alu_b      = req.rs2;
            end
            TGT: begin
                alu_op = ALU_ADD;
                alu_a  = req.pc;
                alu_b  = taken_q ? req.imm : XLEN'(4);
            end
            default: ;
        endcase
    end

    assign br_ready       = (state == IDLE) & ~flush;
    assign redir_valid    = vld_q;
    assign redir_taken    = vld_q & taken_q;
    assign redir_illegal  = vld_q & illegal_q;
    assign redir_misalign = vld_q & misalign_q;
    assign redir_target   = vld_q ? target_q : '0;

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
    localparam int XLEN = 32;
    localparam logic [3:0] ALU_ADD     = 4'h0;
    localparam logic [3:0] ALU_SUB     = 4'h1;
    localparam logic [3:0] ALU_NOP     = 4'hF;
    localparam logic [2:0] ALU_CMP_NOP = 3'h0;
    localparam logic [2:0] CMP_EQ      = 3'h1;
    localparam logic [2:0] CMP_NE      = 3'h2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            br_valid = 1'b0;
    logic            br_ready;
    logic [XLEN-1:0] br_pc = '0, br_imm = '0, br_rs1_val = '0, br_rs2_val = '0;
    logic [3:0]      br_alu_op = '0;
    logic [2:0]      br_cmp_op = '0;
    logic [3:0]      alu_op;
    logic [2:0]      alu_cmp_op;
    logic [XLEN-1:0] alu_a, alu_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_cmp_flag;
    logic            flush = 1'b0;
    logic            redir_valid;
    logic            redir_ready = 1'b0;
    logic            redir_taken, redir_illegal, redir_misalign;
    logic [XLEN-1:0] redir_target;
    logic [31:0]     taken_cnt;
    logic            flag_force = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    branch_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready),
        .br_pc(br_pc), .br_imm(br_imm), .br_rs1_val(br_rs1_val), .br_rs2_val(br_rs2_val),
        .br_alu_op(br_alu_op), .br_cmp_op(br_cmp_op),
        .alu_op(alu_op), .alu_cmp_op(alu_cmp_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_cmp_flag(alu_cmp_flag),
        .flush(flush),
        .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_taken(redir_taken), .redir_illegal(redir_illegal),
        .redir_misalign(redir_misalign), .redir_target(redir_target),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    // Small shared-ALU model: adder plus EQ/NE comparator.
    always_comb begin
        alu_result   = (alu_op == ALU_ADD) ? alu_a + alu_b : '0;
        alu_cmp_flag = flag_force;
        if (alu_cmp_op == CMP_EQ) alu_cmp_flag = (alu_a == alu_b);
        if (alu_cmp_op == CMP_NE) alu_cmp_flag = (alu_a != alu_b);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Offers a branch and walks it to RESP, checking the ALU drive on the way.
    // Returns at the negedge inside RESP.
    task automatic issue(input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [2:0] cop, input logic exp_taken);
        @(negedge clk);
        chk("br_ready_idle", br_ready, 1);
        br_pc = pc; br_imm = imm; br_rs1_val = rs1; br_rs2_val = rs2;
        br_alu_op = ALU_SUB; br_cmp_op = cop; br_valid = 1'b1;
        @(negedge clk);  // handshake edge N passed -> CMP
        br_valid = 1'b0;
        chk("cmp_alu_op", alu_op, ALU_SUB);
        chk("cmp_cmp_op", alu_cmp_op, cop);
        chk("cmp_alu_a", alu_a, rs1);
        chk("cmp_alu_b", alu_b, rs2);
        chk("cmp_br_ready", br_ready, 0);
        chk("cmp_valid", redir_valid, 0);
        @(negedge clk);  // TGT
        chk("tgt_alu_op", alu_op, ALU_ADD);
        chk("tgt_cmp_op", alu_cmp_op, ALU_CMP_NOP);
        chk("tgt_alu_a", alu_a, pc);
        chk("tgt_alu_b", alu_b, exp_taken ? imm : 32'd4);
        chk("tgt_valid", redir_valid, 0);
        @(negedge clk);  // RESP: seen high by the consumer at edge N+3
        chk("resp_valid", redir_valid, 1);
        chk("resp_alu_op", alu_op, ALU_NOP);
        chk("resp_alu_a", alu_a, 0);
    endtask

    task automatic accept(input logic t, input logic ill, input logic mis,
                          input logic [31:0] tgt, input logic [31:0] cnt);
        chk("redir_taken", redir_taken, t);
        chk("redir_illegal", redir_illegal, ill);
        chk("redir_misalign", redir_misalign, mis);
        chk("redir_target", redir_target, tgt);
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk("post_valid", redir_valid, 0);
        chk("post_target_zero", redir_target, 0);
        chk("post_taken_zero", redir_taken, 0);
        chk("taken_cnt", taken_cnt, cnt);
        chk("post_br_ready", br_ready, 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", redir_valid, 0);
        chk("rst_taken", redir_taken, 0);
        chk("rst_illegal", redir_illegal, 0);
        chk("rst_misalign", redir_misalign, 0);
        chk("rst_target", redir_target, 0);
        chk("rst_cnt", taken_cnt, 0);
        chk("rst_alu_op", alu_op, ALU_NOP);
        chk("rst_cmp_op", alu_cmp_op, ALU_CMP_NOP);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_br_ready", br_ready, 1);

        // BEQ taken
        issue(32'h100, 32'h20, 32'd5, 32'd5, CMP_EQ, 1'b1);
        accept(1'b1, 1'b0, 1'b0, 32'h120, 32'd1);

        // BNE not taken
        issue(32'h100, 32'h20, 32'd7, 32'd7, CMP_NE, 1'b0);
        accept(1'b0, 1'b0, 1'b0, 32'h104, 32'd1);

        // Wrap-around target, misaligned
        issue(32'hFFFF_FFFC, 32'h6, 32'd9, 32'd9, CMP_EQ, 1'b1);
        accept(1'b1, 1'b0, 1'b1, 32'h2, 32'd2);

        // Illegal compare with flag forced high, then 5 cycles of backpressure
        flag_force = 1'b1;
        issue(32'h200, 32'h40, 32'd1, 32'd2, ALU_CMP_NOP, 1'b0);
        flag_force = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", redir_valid, 1);
            chk("bp_illegal", redir_illegal, 1);
            chk("bp_target", redir_target, 32'h204);
            chk("bp_br_ready", br_ready, 0);
            @(negedge clk);
        end
        accept(1'b0, 1'b1, 1'b0, 32'h204, 32'd2);

        // Flush while in TGT
        @(negedge clk);
        br_pc = 32'h300; br_imm = 32'h8; br_rs1_val = 32'd3; br_rs2_val = 32'd3;
        br_cmp_op = CMP_EQ; br_valid = 1'b1;
        @(negedge clk);  // CMP
        br_valid = 1'b0;
        @(negedge clk);  // TGT
        chk("fl_in_tgt", alu_op, ALU_ADD);
        flush = 1'b1;
        #1;
        chk("fl_br_ready", br_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_valid", redir_valid, 0);
        chk("fl_br_ready_after", br_ready, 1);
        chk("fl_alu_op", alu_op, ALU_NOP);
        repeat (2) begin
            @(negedge clk);
            chk("fl_valid_later", redir_valid, 0);
        end
        chk("fl_cnt", taken_cnt, 32'd2);

        // Flush beats redir_ready in RESP: no count, no redirect
        issue(32'h400, 32'h10, 32'd4, 32'd4, CMP_EQ, 1'b1);
        redir_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0; flush = 1'b0;
        chk("flr_valid", redir_valid, 0);
        chk("flr_cnt", taken_cnt, 32'd2);

        // Asynchronous reset in RESP
        issue(32'h500, 32'h10, 32'd6, 32'd6, CMP_EQ, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", redir_valid, 0);
        chk("ar_cnt", taken_cnt, 0);
        chk("ar_target", redir_target, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_br_ready", br_ready, 1);
        chk("ar_valid_after", redir_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter XLEN, 32, datapath width for PC, operands, immediate and ALU ports.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 br_valid  input  1  decoded B-type branch offered.
REQ-005 br_ready  output  1  controller can accept a branch.
REQ-006 br_pc, br_imm, br_rs1_val, br_rs2_val  input  XLEN each  branch PC, sign-extended immediate, rs1/rs2 register values.
REQ-007 br_alu_op  input  4  ALU opcode from the B-type decoder.
REQ-008 br_cmp_op  input  3  compare opcode from the B-type decoder.
REQ-009 alu_op  output  4  opcode driven to the shared ALU.
REQ-010 alu_cmp_op  output  3  compare opcode driven to the shared ALU.
REQ-011 alu_a, alu_b  output  XLEN each  ALU operands.
REQ-012 alu_result  input  XLEN  combinational ALU result, valid in the same cycle.
REQ-013 alu_cmp_flag  input  1  combinational ALU compare outcome for alu_cmp_op.
REQ-014 flush  input  1  synchronous pipeline kill.
REQ-015 redir_valid  output  1  resolution result available.
REQ-016 redir_ready  input  1  consumer accepts the result.
REQ-017 redir_taken, redir_illegal, redir_misalign  output  1 each  taken, illegal-func3 and target-misaligned flags.
REQ-018 redir_target  output  XLEN  next PC.
REQ-019 taken_cnt  output  32  count of accepted taken branches.

Function
REQ-020 FSM states: IDLE, CMP, TGT, RESP; every state change occurs on a rising clk edge.
REQ-021 br_ready is 1 only in IDLE with flush=0.
REQ-022 In IDLE, br_valid&br_ready captures all br_* inputs into holding registers and moves to CMP.
REQ-023 In CMP: alu_op=captured alu_op; alu_cmp_op=captured cmp_op; alu_a=rs1_val; alu_b=rs2_val; taken register <= alu_cmp_flag; next state TGT.
REQ-024 A captured cmp_op equal to ALU_CMP_NOP sets the illegal flag, forces taken=0 regardless of alu_cmp_flag, and still proceeds to TGT.
REQ-025 In TGT: alu_op=ALU_ADD; alu_cmp_op=ALU_CMP_NOP; alu_a=pc; alu_b=taken ? imm : 4; target register <= alu_result; next state RESP.
REQ-026 misalign flag is registered in TGT as taken & (alu_result[1:0] != 0); it is 0 when not taken.
REQ-027 In IDLE and RESP: alu_op=ALU_NOP, alu_cmp_op=ALU_CMP_NOP, alu_a=alu_b=0.
REQ-028 In RESP: redir_valid=1 and the redir_* outputs are held stable until redir_valid&redir_ready, then the FSM returns to IDLE.
REQ-029 redir_* flag and target outputs are registered values and read 0 whenever redir_valid=0.
REQ-030 Latency: handshake at edge N gives redir_valid=1 from edge N+3; throughput is at most one branch per 4 cycles with redir_ready held at 1.
REQ-031 taken_cnt increments by 1 on each RESP handshake with taken=1 and wraps from 0xFFFFFFFF to 0.
REQ-032 flush=1 in any state forces IDLE at the next edge, discards the in-flight branch, does not update taken_cnt, and takes priority over br_valid and redir_ready in the same cycle.
REQ-033 Target arithmetic is modulo 2^XLEN; the carry is discarded.

Reset
REQ-034 rst_n=0 asynchronously forces IDLE and clears all holding registers.
REQ-035 During and after reset: redir_valid=0, redir_taken=0, redir_illegal=0, redir_misalign=0, redir_target=0, taken_cnt=0, alu_op=ALU_NOP, alu_cmp_op=ALU_CMP_NOP.
REQ-036 br_ready=1 from the first edge after rst_n deasserts, with flush=0.
REQ-037 Reset asserted mid-operation (CMP/TGT/RESP) aborts the branch with no redirect issued.

Verification
REQ-038 BEQ: pc=0x100, imm=0x20, rs1=rs2=5, ALU model flag=1 -> redir_valid at N+3, taken=1, target=0x120, taken_cnt=1.
REQ-039 BNE not taken: pc=0x100, rs1=rs2=7 -> taken=0, target=0x104, taken_cnt unchanged.
REQ-040 Wrap and misalign: pc=0xFFFFFFFC, imm=0x6, taken -> target=0x00000002, misalign=1.
REQ-041 Illegal and backpressure: cmp_op=ALU_CMP_NOP -> illegal=1, taken=0, target=pc+4; redir_ready held 0 for 5 cycles -> outputs stable, br_ready=0 throughout.
REQ-042 Flush in TGT -> IDLE next edge, redir_valid never asserted; br_ready=1 the following cycle.
REQ-043 rst_n pulsed low in RESP -> redir_valid drops immediately (asynchronously), taken_cnt=0.
